b_bop_stage: RTL and testbench

//  Pipelined, handshaked wrapper for the ternary bitwise bop unit (b_bop).

---
 rtl/b_bop_stage.sv | 111 +++++++++++
 tb/tb_b_bop_stage.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/b_bop_stage.sv
// Two-stage handshaked wrapper around the ternary bitwise bop function:
// an operand register (stage A) feeding a small in-order result FIFO (stage B).
//
// Handshake rules (both sides): a transfer happens on a rising edge where
// valid & ready are both high; valid never waits on ready, and in_ready is
// derived from registered state and flush only, so no ready path crosses
// the stage.
module b_bop_stage #(
    parameter int OUT_DEPTH = 2
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_rd,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic [7:0]  in_lut,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        busy
);

    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(OUT_DEPTH);

    // Stage A: operand register
    logic        a_valid_q, a_valid_d;
    logic [31:0] a_rd_q;
    logic [31:0] a_rs1_q;
    logic [31:0] a_rs2_q;
    logic [7:0]  a_lut_q;

    // Stage B: result FIFO
    logic [31:0]      fifo_q [OUT_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic        full;
    logic        push;
    logic        pop;
    logic        accept;
    logic [31:0] bop_res;

    assign full      = (count_q == DEPTH_C);
    assign push      = a_valid_q & ~full;
    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    assign in_ready  = (~a_valid_q | ~full) & ~flush;
    assign accept    = in_valid & in_ready;
    assign busy      = a_valid_q | (count_q != '0);
    assign out_result = fifo_q[rd_ptr_q];

    // Each result bit selects one truth-table entry by {rd, rs2, rs1}.
    always_comb begin
        bop_res = '0;
        for (int i = 0; i < 32; i++) begin
            bop_res[i] = a_lut_q[{a_rd_q[i], a_rs2_q[i], a_rs1_q[i]}];
        end
    end

    always_comb begin
        a_valid_d = (a_valid_q & ~push) | accept;
        rd_ptr_d  = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        count_d   = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state: reset first, then flush, then normal update.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            a_valid_q <= 1'b0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
        end else if (flush) begin
            a_valid_q <= 1'b0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            a_valid_q <= a_valid_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
        end
    end

    // Datapath registers carry no reset; validity is tracked above.
    always_ff @(posedge g_clk) begin
        if (accept) begin
            a_rd_q  <= in_rd;
            a_rs1_q <= in_rs1;
            a_rs2_q <= in_rs2;
            a_lut_q <= in_lut;
        end
        if (push && !flush) begin
            fifo_q[wr_ptr_q] <= bop_res;
        end
    end

endmodule

// File: tb/tb_b_bop_stage.sv
// Self-checking bench for b_bop_stage: queue-based occupancy model with a
// sum-of-minterms reference for the bop function, plus directed literal checks.
module tb_b_bop_stage;

    localparam int D = 2;

    logic        g_clk = 1'b0;
    logic        g_resetn = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_rd = '0;
    logic [31:0] in_rs1 = '0;
    logic [31:0] in_rs2 = '0;
    logic [7:0]  in_lut = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        busy;

    b_bop_stage #(.OUT_DEPTH(D)) dut (
        .g_clk      (g_clk),
        .g_resetn   (g_resetn),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_lut     (in_lut),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .busy       (busy)
    );

    always #5 g_clk = ~g_clk;

    int n_checks = 0;
    int n_pass = 0;
    bit checking = 1'b0;

    // Model: op waiting in the operand register, and results queued for output.
    logic [31:0] a_q[$];
    logic [31:0] exp_q[$];

    logic        obs_valid, obs_ready, obs_busy;
    logic [31:0] obs_result;

    function automatic logic [31:0] bop_ref(input logic [7:0] lut, input logic [31:0] rd,
                                            input logic [31:0] rs1, input logic [31:0] rs2);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            if (lut[k]) r |= (((k & 4) != 0) ? rd : ~rd) & (((k & 2) != 0) ? rs2 : ~rs2)
                             & (((k & 1) != 0) ? rs1 : ~rs1);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic set_op(input logic [7:0] lut, input logic [31:0] rd,
                          input logic [31:0] rs1, input logic [31:0] rs2);
        in_lut = lut;
        in_rd  = rd;
        in_rs1 = rs1;
        in_rs2 = rs2;
    endtask

    task automatic rand_op();
        set_op(8'($urandom), $urandom, $urandom, $urandom);
    endtask

    // One clock: compare at negedge, advance the model at posedge.
    task automatic cycle();
        bit full, pop, push, acc;
        @(negedge g_clk);
        if (checking) begin
            check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            check("in_ready", 32'(in_ready),
                  32'(((a_q.size() == 0) || (exp_q.size() < D)) && !flush));
            check("busy", 32'(busy), 32'((a_q.size() != 0) || (exp_q.size() != 0)));
            if (out_valid && exp_q.size() != 0) check("out_result", out_result, exp_q[0]);
        end
        obs_valid  = out_valid;
        obs_ready  = in_ready;
        obs_busy   = busy;
        obs_result = out_result;
        @(posedge g_clk);
        if (!g_resetn || flush) begin
            a_q.delete();
            exp_q.delete();
        end else begin
            full = (exp_q.size() == D);
            pop  = (exp_q.size() != 0) && out_ready;
            push = (a_q.size() != 0) && !full;
            acc  = in_valid && ((a_q.size() == 0) || !full);
            if (pop)  void'(exp_q.pop_front());
            if (push) exp_q.push_back(a_q.pop_front());
            if (acc)  a_q.push_back(bop_ref(in_lut, in_rd, in_rs1, in_rs2));
        end
        #1;
    endtask

    task automatic latency_test(input string tag);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        set_op(8'h96, 32'hFFFF0000, 32'h0F0F0F0F, 32'h00FF00FF);
        cycle();
        check({tag, "_accept"}, 32'(obs_ready), 32'd1);
        in_valid = 1'b0;
        cycle();
        check({tag, "_n1_valid"}, 32'(obs_valid), 32'd0);
        cycle();
        check({tag, "_n2_valid"}, 32'(obs_valid), 32'd1);
        check({tag, "_n2_result"}, obs_result, 32'hF00F0FF0);
    endtask

    initial begin
        logic [31:0] got[$];
        int          got_cyc[$];
        logic [7:0]  luts[4];
        logic [31:0] want[4];
        int          acc, pops;
        bit          seen_ready;

        luts = '{8'hAA, 8'hCC, 8'hF0, 8'hE8};
        want = '{32'h0F0F0F0F, 32'h00FF00FF, 32'hFFFF0000, 32'h0FFF000F};

        // Reset
        g_resetn = 1'b0;
        cycle();
        cycle();
        g_resetn = 1'b1;
        checking = 1'b1;
        cycle();
        check("rst_out_valid", 32'(obs_valid), 32'd0);
        check("rst_in_ready", 32'(obs_ready), 32'd1);
        check("rst_busy", 32'(obs_busy), 32'd0);

        // Latency N+2 with XOR3 table
        latency_test("lat");

        // Back-to-back tables, one result per cycle, in order
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k < 4) begin
                in_valid = 1'b1;
                set_op(luts[k], 32'hFFFF0000, 32'h0F0F0F0F, 32'h00FF00FF);
            end else begin
                in_valid = 1'b0;
            end
            cycle();
            if (obs_valid) begin
                got.push_back(obs_result);
                got_cyc.push_back(k);
            end
        end
        check("b2b_count", 32'(got.size()), 32'd4);
        if (got.size() == 4) begin
            for (int k = 0; k < 4; k++) check("b2b_result", got[k], want[k]);
            check("b2b_first_cyc", 32'(got_cyc[0]), 32'd2);
            check("b2b_last_cyc", 32'(got_cyc[3]), 32'd5);
        end

        // Capacity: output stalled, request held
        out_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            rand_op();
            in_valid = 1'b1;
            cycle();
            if (obs_ready) acc++;
        end
        check("cap_accepted", 32'(acc), 32'd3);
        check("cap_in_ready", 32'(obs_ready), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        pops = 0;
        seen_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (obs_ready) seen_ready = 1'b1;
            if (obs_valid) pops++;
        end
        check("cap_drained", 32'(pops), 32'd3);
        check("cap_ready_back", 32'(seen_ready), 32'd1);
        check("cap_idle", 32'(obs_busy), 32'd0);

        // Full FIFO, sustained throughput
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rand_op();
            in_valid = 1'b1;
            cycle();
        end
        out_ready = 1'b1;
        pops = 0;
        for (int k = 0; k < 20; k++) begin
            rand_op();
            in_valid = 1'b1;
            cycle();
            if (obs_valid) pops++;
        end
        check("thru_pops", 32'(pops), 32'd20);
        in_valid = 1'b0;
        for (int k = 0; k < 6; k++) cycle();

        // Flush with three ops in flight
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rand_op();
            in_valid = 1'b1;
            cycle();
        end
        flush = 1'b1;
        out_ready = 1'b1;
        rand_op();
        cycle();
        check("flush_in_ready", 32'(obs_ready), 32'd0);
        flush = 1'b0;
        in_valid = 1'b0;
        cycle();
        check("flush_out_valid", 32'(obs_valid), 32'd0);
        check("flush_busy", 32'(obs_busy), 32'd0);
        latency_test("postflush");

        // Reset mid-stream
        for (int k = 0; k < 10; k++) begin
            rand_op();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) == 0);
            cycle();
        end
        in_valid = 1'b0;
        g_resetn = 1'b0;
        cycle();
        g_resetn = 1'b1;
        cycle();
        check("mrst_out_valid", 32'(obs_valid), 32'd0);
        check("mrst_in_ready", 32'(obs_ready), 32'd1);
        check("mrst_busy", 32'(obs_busy), 32'd0);

        // Random soak with stalls, rare flushes and resets
        for (int k = 0; k < 3000; k++) begin
            rand_op();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 99) == 0);
            g_resetn  = ($urandom_range(0, 199) != 0);
            cycle();
        end
        flush = 1'b0;
        g_resetn = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) cycle();
        check("soak_idle", 32'(obs_busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
